// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU core.
package alu_seq_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    // Flag vector layout {Z,N,C,V}
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_XNOR  = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_SRA   = 4'd9,
        OP_ADC   = 4'd10,
        OP_CMP   = 4'd11,
        OP_MUL   = 4'd12,
        OP_ILL13 = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/handshake/result bundle between the operand bus master and the ALU core.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
) ();
    import alu_seq_pkg::*;

    logic [WIDTH-1:0]  in1;
    logic [WIDTH-1:0]  in2;
    logic              in1_en;
    logic              in2_en;
    logic [OP_W-1:0]   op;
    logic              start;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [FLAG_W-1:0] flags;
    logic              err;

    modport master (
        output in1, in2, in1_en, in2_en, op, start,
        input  busy, done, result, flags, err
    );

    modport slave (
        input  in1, in2, in1_en, in2_en, op, start,
        output busy, done, result, flags, err
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// o_valid_c is high in the cycle whose closing edge writes the final product.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid_c,
    output logic [2*WIDTH-1:0] o_product
);
    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [PROD_W-1:0] r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    assign o_valid_c = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

    // Load operands on start, then accumulate one shifted multiplicand per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            o_product <= '0;
        end else if (i_start) begin
            r_mcand   <= PROD_W'(i_a);
            r_mplier  <= i_b;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            o_product <= '0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                o_product <= o_product + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_valid_c) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with operand registers, start/busy/done handshake, registered
// {Z,N,C,V} flags and a tristate result bus driver.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (opcode 12).
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    input  logic             bus_oe,
    output wire [WIDTH-1:0]  bus_out
);
    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH-1:0]  r_a_q;
    logic [WIDTH-1:0]  r_b_q;
    logic [WIDTH-1:0]  r_wa;
    logic [WIDTH-1:0]  r_wb;
    op_e               r_op;
    state_e            r_state;
    logic [WIDTH-1:0]  r_result;
    logic [FLAG_W-1:0] r_flags;
    logic              r_err;
    logic              r_busy;
    logic              r_done;

    state_e            w_state_nxt;
    logic [WIDTH-1:0]  w_result_nxt;
    logic [FLAG_W-1:0] w_flags_nxt;
    logic              w_err_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_accept;

    logic [WIDTH-1:0]   w_alu_res;
    logic [FLAG_W-1:0]  w_alu_flags;
    logic               w_c;
    logic               w_v;
    logic               w_legal;
    logic [W1-1:0]      w_add;
    logic [W1-1:0]      w_sub;
    logic [W1-1:0]      w_shl;
    logic [W1-1:0]      w_shr;
    logic signed [W1-1:0] w_sra_in;
    logic [W1-1:0]      w_sra;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_cin;
    logic               w_mul_last_c;

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.flags  = r_flags;
    assign bus.err    = r_err;

    assign bus_out = bus_oe ? r_result : {WIDTH{1'bz}};

`ifdef ALU_SEQ_MUL_EN
    logic               w_mul_start;
    logic [2*WIDTH-1:0] w_product;

    assign w_mul_start = w_accept && (op_e'(bus.op) == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (r_a_q),
        .i_b       (r_b_q),
        .o_valid_c (w_mul_last_c),
        .o_product (w_product)
    );
`else
    assign w_mul_last_c = 1'b0;
`endif

    // Carry, borrow and shift-out bits come from one extra MSB/LSB
    assign w_cin    = (r_op == OP_ADC) ? r_flags[FLAG_C] : 1'b0;
    assign w_add    = W1'(r_wa) + W1'(r_wb) + W1'(w_cin);
    assign w_sub    = W1'(r_wa) - W1'(r_wb);
    assign w_shamt  = r_wb[SHAMT_W-1:0];
    assign w_shl    = W1'(r_wa) << w_shamt;
    assign w_shr    = {r_wa, 1'b0} >> w_shamt;
    assign w_sra_in = {r_wa, 1'b0};
    assign w_sra    = w_sra_in >>> w_shamt;

    // Result and flag computation for the captured operation
    always_comb begin
        w_alu_res = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_legal   = 1'b1;
        case (r_op)
            OP_ADD, OP_ADC: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_c       = w_add[WIDTH];
                w_v       = (r_wa[WIDTH-1] == r_wb[WIDTH-1]) && (w_add[WIDTH-1] != r_wa[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_c       = w_sub[WIDTH];
                w_v       = (r_wa[WIDTH-1] != r_wb[WIDTH-1]) && (w_sub[WIDTH-1] != r_wa[WIDTH-1]);
            end
            OP_AND:  w_alu_res = r_wa & r_wb;
            OP_OR:   w_alu_res = r_wa | r_wb;
            OP_XOR:  w_alu_res = r_wa ^ r_wb;
            OP_NOR:  w_alu_res = ~(r_wa | r_wb);
            OP_XNOR: w_alu_res = ~(r_wa ^ r_wb);
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_c       = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                w_c       = w_shr[0];
            end
            OP_SRA: begin
                w_alu_res = w_sra[WIDTH:1];
                w_c       = w_sra[0];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                w_alu_res = w_product[WIDTH-1:0];
                w_c       = |w_product[2*WIDTH-1:WIDTH];
                w_v       = w_c;
            end
`endif
            default: w_legal = 1'b0;
        endcase
        w_alu_flags         = '0;
        w_alu_flags[FLAG_Z] = (w_alu_res == '0);
        w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_V] = w_v;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_err_nxt    = r_err;
        w_done_nxt   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DONE;
`ifdef ALU_SEQ_MUL_EN
                    if (op_e'(bus.op) == OP_MUL) begin
                        w_state_nxt = MUL;
                    end
`endif
                end
            end
            MUL: begin
                if (w_mul_last_c) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
                if (w_legal) begin
                    w_flags_nxt = w_alu_flags;
                    w_err_nxt   = 1'b0;
                    if (r_op != OP_CMP) begin
                        w_result_nxt = w_alu_res;
                    end
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Operand registers load independently of the running operation
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            if (bus.in1_en) r_a_q <= bus.in1;
            if (bus.in2_en) r_b_q <= bus.in2;
        end
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_wa     <= '0;
            r_wb     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            if (w_accept) begin
                r_op <= op_e'(bus.op);
                r_wa <= r_a_q;
                r_wb <= r_b_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=16 and WIDTH=32.
// MUL scenarios run only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq_core;
    logic clk;
    logic rst;
    logic oe16;
    logic oe32;
    wire [15:0] w_bus16;
    wire [31:0] w_bus32;
    int checks   = 0;
    int failures = 0;

    alu_seq_if #(.WIDTH(16)) if16 ();
    alu_seq_if #(.WIDTH(32)) if32 ();

    alu_seq_core #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (if16),
        .bus_oe  (oe16),
        .bus_out (w_bus16)
    );

    alu_seq_core #(.WIDTH(32)) dut32 (
        .clk     (clk),
        .rst     (rst),
        .bus     (if32),
        .bus_oe  (oe32),
        .bus_out (w_bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load16(input logic [15:0] a, input logic [15:0] b);
        if16.in1 = a;
        if16.in2 = b;
        if16.in1_en = 1'b1;
        if16.in2_en = 1'b1;
        tick();
        if16.in1_en = 1'b0;
        if16.in2_en = 1'b0;
    endtask

    // Single-cycle op: busy after the start edge, done and outputs one edge later
    task automatic run1(input string tag, input logic [3:0] opc, input logic [15:0] er,
                        input logic [3:0] ef, input logic ee);
        if16.op = opc;
        if16.start = 1'b1;
        tick();
        if16.start = 1'b0;
        chk({tag, "_busy"}, 64'(if16.busy), 64'd1);
        chk({tag, "_early_done"}, 64'(if16.done), 64'd0);
        tick();
        chk({tag, "_done"}, 64'(if16.done), 64'd1);
        chk({tag, "_result"}, 64'(if16.result), 64'(er));
        chk({tag, "_flags"}, 64'(if16.flags), 64'(ef));
        chk({tag, "_err"}, 64'(if16.err), 64'(ee));
        chk({tag, "_idle"}, 64'(if16.busy), 64'd0);
    endtask

`ifdef ALU_SEQ_MUL_EN
    // Multiply: count edges from the start edge to the done pulse
    task automatic runmul(input string tag, input logic [15:0] er, input logic [3:0] ef,
                          input logic poke);
        int k;
        k = 0;
        if16.op = 4'd12;
        if16.start = 1'b1;
        tick();
        if16.start = 1'b0;
        if (poke) begin
            if16.op = 4'd0;
            if16.start = 1'b1;
        end
        while (k < 40 && if16.done !== 1'b1) begin
            tick();
            if16.start = 1'b0;
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd17);
        chk({tag, "_result"}, 64'(if16.result), 64'(er));
        chk({tag, "_flags"}, 64'(if16.flags), 64'(ef));
        chk({tag, "_err"}, 64'(if16.err), 64'd0);
        tick();
        chk({tag, "_single_done"}, 64'(if16.done), 64'd0);
        chk({tag, "_idle"}, 64'(if16.busy), 64'd0);
    endtask
`endif

    initial begin
        rst = 1'b0;
        oe16 = 1'b0;
        oe32 = 1'b1;
        if16.in1 = '0; if16.in2 = '0; if16.in1_en = 1'b0; if16.in2_en = 1'b0;
        if16.op = '0; if16.start = 1'b0;
        if32.in1 = '0; if32.in2 = '0; if32.in1_en = 1'b0; if32.in2_en = 1'b0;
        if32.op = '0; if32.start = 1'b0;
        tick();
        tick();
        chk("rst_result", 64'(if16.result), 64'd0);
        chk("rst_flags", 64'(if16.flags), 64'd0);
        chk("rst_err", 64'(if16.err), 64'd0);
        chk("rst_busy", 64'(if16.busy), 64'd0);
        chk("rst_done", 64'(if16.done), 64'd0);
        rst = 1'b1;
        tick();

        // Arithmetic with overflow, borrow and compare
        load16(16'h7FFF, 16'h0001);
        run1("add_ovf", 4'd0, 16'h8000, 4'b0101, 1'b0);
        load16(16'h0003, 16'h0005);
        run1("sub_borrow", 4'd1, 16'hFFFE, 4'b0110, 1'b0);
        load16(16'h1234, 16'h1234);
        run1("cmp_eq", 4'd11, 16'hFFFE, 4'b1000, 1'b0);

        // Shifts, including last bit out and zero shift amount
        load16(16'h8001, 16'h0001);
        run1("sra1", 4'd9, 16'hC000, 4'b0110, 1'b0);
        run1("shr1", 4'd8, 16'h4000, 4'b0010, 1'b0);
        load16(16'h8001, 16'h0000);
        run1("shl0", 4'd7, 16'h8001, 4'b0100, 1'b0);
        load16(16'hF001, 16'h0004);
        run1("shl4", 4'd7, 16'h0010, 4'b0010, 1'b0);

        // Logic ops
        load16(16'h8001, 16'h00FF);
        run1("xor", 4'd4, 16'h80FE, 4'b0100, 1'b0);
        run1("nor", 4'd5, 16'h7F00, 4'b0000, 1'b0);
        run1("and", 4'd2, 16'h0001, 4'b0000, 1'b0);
        run1("or", 4'd3, 16'h80FF, 4'b0100, 1'b0);
        run1("xnor", 4'd6, 16'h7F01, 4'b0000, 1'b0);

        // Carry chain: ADD sets C, ADC consumes it
        load16(16'hFFFF, 16'h0001);
        run1("add_carry", 4'd0, 16'h0000, 4'b1010, 1'b0);
        load16(16'h0001, 16'h0001);
        run1("adc", 4'd10, 16'h0003, 4'b0000, 1'b0);
        load16(16'h8000, 16'h0001);
        run1("sub_ovf", 4'd1, 16'h7FFF, 4'b0001, 1'b0);

        // Illegal opcodes hold result/flags and set err
        run1("ill14", 4'd14, 16'h7FFF, 4'b0001, 1'b1);
`ifndef ALU_SEQ_MUL_EN
        run1("ill12", 4'd12, 16'h7FFF, 4'b0001, 1'b1);
`endif
        load16(16'h0001, 16'h0001);
        // A reload in the start cycle does not reach the operation
        if16.in1 = 16'h0010;
        if16.in1_en = 1'b1;
        run1("add_clr_err", 4'd0, 16'h0002, 4'b0000, 1'b0);
        if16.in1_en = 1'b0;
        run1("add_new_a", 4'd0, 16'h0011, 4'b0000, 1'b0);

        // Bus driver; a 2-state simulator resolves an undriven net to 0
        oe16 = 1'b1;
        #1;
        chk("bus_drive", 64'(w_bus16), 64'h0011);
        oe16 = 1'b0;
        #1;
        chk("bus_release", 64'((w_bus16 === 16'hzzzz) || (w_bus16 === 16'h0000)), 64'd1);

`ifdef ALU_SEQ_MUL_EN
        load16(16'h0003, 16'h0005);
        runmul("mul_small", 16'h000F, 4'b0000, 1'b0);
        load16(16'h0100, 16'h0100);
        runmul("mul_big", 16'h0000, 4'b1011, 1'b1);
        begin
            int seen;
            seen = 0;
            load16(16'h00FF, 16'h00FF);
            if16.op = 4'd12;
            if16.start = 1'b1;
            tick();
            if16.start = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            rst = 1'b0;
            tick();
            rst = 1'b1;
            chk("mulrst_result", 64'(if16.result), 64'd0);
            chk("mulrst_flags", 64'(if16.flags), 64'd0);
            chk("mulrst_busy", 64'(if16.busy), 64'd0);
            chk("mulrst_err", 64'(if16.err), 64'd0);
            for (int i = 0; i < 25; i++) begin
                tick();
                if (if16.done === 1'b1) seen++;
            end
            chk("mulrst_no_done", 64'(seen), 64'd0);
        end
`endif

        // WIDTH=32 repeat of the signed-overflow add
        if32.in1 = 32'h7FFF_FFFF;
        if32.in2 = 32'h0000_0001;
        if32.in1_en = 1'b1;
        if32.in2_en = 1'b1;
        tick();
        if32.in1_en = 1'b0;
        if32.in2_en = 1'b0;
        if32.op = 4'd0;
        if32.start = 1'b1;
        tick();
        if32.start = 1'b0;
        chk("w32_busy", 64'(if32.busy), 64'd1);
        tick();
        chk("w32_done", 64'(if32.done), 64'd1);
        chk("w32_result", 64'(if32.result), 64'h8000_0000);
        chk("w32_flags", 64'(if32.flags), 64'b0101);
        chk("w32_bus", 64'(w_bus32), 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, clocked successor to the 16-bit combinational ALU. It holds operand registers, runs a start/busy/done handshake, adds shift, compare and carry-chain operations, and produces registered status flags. An optional iterative multiplier is compiled in by macro. It sits between the operand bus and the shared data bus, and its result drives that bus through an enable-gated tristate output.

## Interface
Parameters:
- `WIDTH`, default 16: datapath width; must be ≥ 4 and a power of two.
- `SHAMT_W`, default `$clog2(WIDTH)`: width of the shift-amount field taken from `in2`.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low.
- `in1`, `in2`  in  WIDTH  operand inputs.
- `in1_en`, `in2_en`  in  1  load `in1`/`in2` into operand registers `a_q`/`b_q` at the clock edge.
- `op`  in  4  operation select; sampled with `start`.
- `start`  in  1  begin an operation; accepted only when `busy`=0.
- `busy`  out  1  operation in flight; `start` is ignored while high.
- `done`  out  1  one-cycle pulse when `result`, `flags` and `err` update.
- `result`  out  WIDTH  registered result.
- `flags`  out  4  registered {Z,N,C,V}.
- `err`  out  1  registered; set by an illegal opcode.
- `bus_oe`  in  1  bus drive enable.
- `bus_out`  out  WIDTH  `result` when `bus_oe`=1; high-Z otherwise.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 XNOR.
  - 7 SHL, 8 SHR (logical), 9 SRA; shift amount is `b_q[SHAMT_W-1:0]`.
  - 10 ADC (a+b+C), 11 CMP (flags of a−b; `result` unchanged), 12 MUL (low WIDTH bits of a×b).
  - 13–15 illegal.
- `start` captures `op`, `a_q` and `b_q` into working registers. Operand reloads during `busy` are allowed and do not affect the running operation.
- States:
  - IDLE: on `start`, go to MUL if `op`=12 and the multiplier is present; otherwise go to DONE.
  - MUL: one shift-add step per cycle for WIDTH cycles, then go to DONE.
  - DONE: register outputs, pulse `done`, return to IDLE.
- Flags:
  - Z: `result`=0.
  - N: `result[WIDTH-1]`.
  - C:
    - ADD/ADC: carry out.
    - SUB/CMP: borrow (1 when a<b unsigned).
    - Shifts: last bit shifted out (0 when shift amount is 0).
    - Logic ops: 0.
    - MUL: 1 when the upper product half is nonzero.
  - V:
    - ADD/ADC/SUB/CMP: two's-complement overflow.
    - MUL: equal to C.
    - All other ops: 0.
  - CMP updates Z/N from the subtraction result; `result` itself is held.
- Arithmetic wraps modulo 2^WIDTH.
- Illegal opcode: `err`=1; `result` and `flags` are held; `done` still pulses. Any legal completion clears `err`.
- Reset: `result`, `flags`, `err`, `busy`, `done`, `a_q`, `b_q` go to 0; state goes to IDLE. A reset mid-MUL aborts the operation and no `done` pulse is produced.

## Timing
- Single-cycle ops: `start` accepted at edge n; `done`=1 and outputs valid after edge n+1. Latency 1, throughput one op every 2 cycles.
- MUL: `busy`=1 for WIDTH+1 cycles; `done` after edge n+WIDTH+1.
- `busy` is high from the edge after `start` through the `done` cycle, inclusive.
- `start` and `in1_en` in the same cycle: the operation uses the old `a_q`; the new value lands in `a_q` at that edge.
- `bus_out` is combinational from `bus_oe` and `result`, with no added latency.

## Configuration
- `ALU_SEQ_MUL_EN` defined: the iterative multiplier is built and opcode 12 is legal.
- `ALU_SEQ_MUL_EN` undefined: the multiplier is not built, and opcode 12 is illegal (latency 1, `err`=1).

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode enum,
  - flag index constants (`FLAG_Z`=3, `FLAG_N`=2, `FLAG_C`=1, `FLAG_V`=0),
  - the state enum {IDLE, MUL, DONE}.
- Sub-module `alu_seq_mul`: shift-add multiplier with start/valid, WIDTH cycles, returning a 2·WIDTH product. It is instantiated only under `ALU_SEQ_MUL_EN`.

## Test plan
1. Reset, then load a=0x7FFF, b=0x0001 and run ADD → `result`=0x8000, flags N=1, V=1, C=0, Z=0, `done` one cycle after `start`.
2. Load a=0x0003, b=0x0005 and run SUB → 0xFFFE, C=1, N=1. Then CMP with a=b=0x1234 → Z=1 and `result` still 0xFFFE.
3. Load a=0x8001, b=0x0001 and run SRA → 0xC000, C=1. SHR → 0x4000. SHL with shift amount 0 → 0x8001, C=0.
4. MUL (macro on) with a=0x0100, b=0x0100 → after 17 cycles `result`=0x0000, C=V=1, Z=1. A `start` issued while `busy` is ignored. Assert `rst` at cycle 5 of the MUL → no `done`, all outputs 0.
5. Opcode 14, and opcode 12 with macro off → `err`=1, `result` and `flags` held, `done` pulses. A following ADD clears `err`.
6. `bus_oe`=0 → `bus_out`=Z. `bus_oe`=1 → `bus_out`=`result`. Run with WIDTH=32 and repeat scenario 1 using 0x7FFFFFFF.
